buzz_sched: RTL and testbench
=============================

# buzz_sched

Beep-pattern scheduler that drives the `en_buz` input of the buzzer tone generator. It shares the single buzzer between three requesters: key click, notification beep and alarm. Each requester has a fixed on/off/repeat pattern, and arbitration is fixed-priority with preemption. It sits between the key/FSM logic and the tone generator, and is the only driver of `en_buz`.

## Interface
- `TICK_DIV`, default 50000: clock cycles per 1 ms tick (50 MHz clock). Benches use 4.
- `CLICK_ON`, default 20: ch0 on-time in ms; single pulse.
- `BEEP_ON`, default 100: ch1 on-time in ms.
- `BEEP_OFF`, default 100: ch1 off-time in ms.
- `BEEP_CNT`, default 2: ch1 number of beeps.
- `ALARM_ON`, default 200: ch2 on-time in ms.
- `ALARM_OFF`, default 200: ch2 off-time in ms; repeats until `stop`.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req`, input, 3: per-channel start pulses, sampled each edge. Bit 2 is alarm (highest priority), bit 0 is click.
- `stop`, input, 1: pulse; aborts the active pattern and clears all pending requests.
- `en_buz`, output, 1: enable to the tone generator; high only during on-phases.
- `busy`, output, 1: high whenever state is not IDLE.
- `active_ch`, output, 2: channel being played, 0..2; 3 when idle.

## Operation
- State machine: IDLE, ON, OFF.
- `pend[2:0]` holds requests that are latched but not yet served.
- Every edge, `pend |= req`, then the arbitration and `stop` rules below are applied.
- Registers: phase cycle counter `cyc` (counts 0..TICK_DIV-1), ms counter `ms` (16 bit), beep counter `nb` (8 bit).
- Durations are in ms; one ms equals one `cyc` wrap.
- Durations of 0 are illegal parameters; no checking is required.
- IDLE: if any `pend` bit (including the current-cycle `req`) is set:
  - select the highest set bit and clear it;
  - go to ON with `cyc=ms=nb=0`.
- ON: `en_buz=1`. When `ms` reaches the on-time:
  - ch0, or the last beep of ch1: go to IDLE if nothing is pending, else start the next pattern directly.
  - otherwise: go to OFF, `nb++`.
- OFF: `en_buz=0`. When `ms` reaches the off-time, go to ON.
  - ch2 never counts out; it loops ON/OFF indefinitely.
- Preemption:
  - A `req` or `pend` on a channel higher than `active_ch` aborts the current pattern and restarts in ON with the new channel.
  - The preempted channel is discarded (not re-queued).
- A lower-priority `req` during activity is latched in `pend` and served after the current pattern ends.
- A `req` for the channel already active is ignored; it is neither restarted nor latched.
- `stop`:
  - next state is IDLE; `pend` is cleared; any `req` in the same cycle is also discarded.
  - `stop` has priority over everything.
- Reset (async, any time): IDLE, `pend=0`, all counters 0, `en_buz=0`, `busy=0`, `active_ch=3`.

## Timing
- All outputs are registered.
- A `req` at edge k puts `en_buz`, `busy` and `active_ch` in effect after edge k+1 (1-cycle latency), when the scheduler is IDLE or preempting.
- On-phase length is exactly `ON*TICK_DIV` cycles; off-phase length is exactly `OFF*TICK_DIV` cycles. There is no idle gap between phases.
- Back-to-back patterns: the last on-cycle of pattern A is followed directly by the first on-cycle of pattern B. `en_buz` stays high and `active_ch` changes.
- A preemption mid-phase restarts all counters on the same edge that switches `active_ch`.
- `stop` at edge k: `en_buz=0` and `busy=0` after edge k+1.
- Counter widths:
  - `cyc` is ceil(log2(TICK_DIV)) bits.
  - `ms` is 16 bits; all ms parameters are ≤ 65535.
  - No wrap-around occurs within a legal phase.

## Structure
- Shared package `buzz_pkg`:
  - channel encodings CH_CLICK=0, CH_BEEP=1, CH_ALARM=2, CH_NONE=3;
  - state enum {IDLE, ON, OFF}.
- One sub-module, `ms_tick`:
  - prescaler with sync clear;
  - outputs a 1-cycle tick every TICK_DIV cycles;
  - clear asserted on every phase start.
- Top level holds the arbiter, `pend`, the FSM and the `ms`/`nb` counters.

## Test plan
All scenarios use TICK_DIV=4, CLICK_ON=2, BEEP_ON=3, BEEP_OFF=2, BEEP_CNT=2, ALARM_ON=2, ALARM_OFF=1.

1. Reset with `req` held at 3'b111 → `en_buz=0`, `busy=0`, `active_ch=3` throughout reset.
2. Single `req[0]` pulse → `en_buz` high for exactly 8 cycles starting 1 cycle later, then IDLE.
3. `req[1]` pulse → `en_buz` 12 cycles high, 8 low, 12 high, then `busy=0`; total 32 cycles.
4. `req[2]` pulse, `stop` at cycle 30 → `en_buz` alternates 8 high / 4 low; `busy=0` and `en_buz=0` at cycle 31.
5. `req[1]`, then `req[2]` 5 cycles later → `active_ch` switches 1→2 and the on-phase restarts (8 cycles). `req[0]` raised during the alarm is played after `stop` only if it arrived after `stop`; otherwise it is dropped.
6. `req[2]` active, `req[0]` pulse, then an alarm `stop`-free run is replaced by: ch1 playing + `req[0]` pulse → click plays back-to-back right after ch1's final on-phase, with `en_buz` continuously high across the boundary.

Source files
------------

// File: rtl/buzz_pkg.sv
// Shared definitions for the buzzer pattern scheduler:
// channel codes, FSM states and small arbitration helpers.
package buzz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [1:0] CH_CLICK = 2'd0;
  localparam logic [1:0] CH_BEEP  = 2'd1;
  localparam logic [1:0] CH_ALARM = 2'd2;
  localparam logic [1:0] CH_NONE  = 2'd3;

  // Highest-priority set request; bit 2 (alarm) wins.
  function automatic logic [1:0] top_ch(input logic [2:0] p);
    logic [1:0] ch;
    if (p[2]) begin
      ch = CH_ALARM;
    end else if (p[1]) begin
      ch = CH_BEEP;
    end else if (p[0]) begin
      ch = CH_CLICK;
    end else begin
      ch = CH_NONE;
    end
    return ch;
  endfunction

  function automatic logic [2:0] ch_mask(input logic [1:0] ch);
    logic [2:0] m;
    case (ch)
      CH_CLICK: m = 3'b001;
      CH_BEEP:  m = 3'b010;
      CH_ALARM: m = 3'b100;
      default:  m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/buzz_sched_ms_tick.sv
// Millisecond prescaler: pulses tick for one cycle every TICK_DIV cycles,
// restartable by a synchronous clear so each phase begins on a fresh ms.
module ms_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CYC_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cyc_r;
  logic [CW-1:0] cyc_nx_s;
  logic          tick_r;

  // Next cycle count: wrap at the end of a ms or restart on clear.
  always_comb begin
    cyc_nx_s = cyc_r;
    if (clr || tick_r) begin
      cyc_nx_s = {CW{1'b0}};
    end else begin
      cyc_nx_s = cyc_r + CW'(1);
    end
  end

  // Counter and tick register; tick is high while cyc sits at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_r  <= {CW{1'b0}};
      tick_r <= (CYC_MAX == {CW{1'b0}});
    end else begin
      cyc_r  <= cyc_nx_s;
      tick_r <= (cyc_nx_s == CYC_MAX);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/buzz_sched.sv
// Fixed-priority, preemptive beep-pattern scheduler sharing one buzzer between
// key click (ch0), notification beep (ch1) and alarm (ch2).
module buzz_sched
  import buzz_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int CLICK_ON  = 20,
  parameter int BEEP_ON   = 100,
  parameter int BEEP_OFF  = 100,
  parameter int BEEP_CNT  = 2,
  parameter int ALARM_ON  = 200,
  parameter int ALARM_OFF = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       stop,
  output logic       en_buz,
  output logic       busy,
  output logic [1:0] active_ch
);

  localparam logic [15:0] CLICK_ON_LAST  = 16'(CLICK_ON - 1);
  localparam logic [15:0] BEEP_ON_LAST   = 16'(BEEP_ON - 1);
  localparam logic [15:0] BEEP_OFF_LAST  = 16'(BEEP_OFF - 1);
  localparam logic [15:0] ALARM_ON_LAST  = 16'(ALARM_ON - 1);
  localparam logic [15:0] ALARM_OFF_LAST = 16'(ALARM_OFF - 1);
  localparam logic [7:0]  BEEP_LAST      = 8'(BEEP_CNT - 1);

  state_t      state_r, state_nx_s;
  logic [1:0]  ch_r, ch_nx_s;
  logic [2:0]  pend_r, pend_nx_s;
  logic [15:0] ms_r, ms_nx_s;
  logic [7:0]  nb_r, nb_nx_s;
  logic        en_buz_r, busy_r;
  logic [1:0]  active_ch_r;

  logic        tick_s, clr_s, done_s, last_on_s, start_s;
  logic [2:0]  pend_v_s;
  logic [1:0]  sel_s;
  logic [15:0] on_last_s, off_last_s, phase_last_s;

  ms_tick #(.TICK_DIV(TICK_DIV)) u_ms_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Per-channel phase lengths, expressed as the last ms index of each phase.
  always_comb begin
    on_last_s  = 16'd0;
    off_last_s = 16'd0;
    case (ch_r)
      CH_CLICK: begin on_last_s = CLICK_ON_LAST; off_last_s = 16'd0;          end
      CH_BEEP:  begin on_last_s = BEEP_ON_LAST;  off_last_s = BEEP_OFF_LAST;  end
      CH_ALARM: begin on_last_s = ALARM_ON_LAST; off_last_s = ALARM_OFF_LAST; end
      default:  begin on_last_s = 16'd0;         off_last_s = 16'd0;          end
    endcase
  end

  // Request latching and arbitration; the active channel's own request is masked.
  always_comb begin
    if (state_r != IDLE) begin
      pend_v_s = pend_r | (req & ~ch_mask(ch_r));
    end else begin
      pend_v_s = pend_r | req;
    end
    sel_s = top_ch(pend_v_s);
    if (state_r == ON) begin
      phase_last_s = on_last_s;
    end else begin
      phase_last_s = off_last_s;
    end
    done_s    = tick_s && (ms_r == phase_last_s);
    last_on_s = (ch_r == CH_CLICK) || ((ch_r == CH_BEEP) && (nb_r == BEEP_LAST));
  end

  // Next-state logic; start_s covers idle start, preemption and back-to-back start.
  always_comb begin
    state_nx_s = state_r;
    ch_nx_s    = ch_r;
    pend_nx_s  = pend_v_s;
    ms_nx_s    = tick_s ? (ms_r + 16'd1) : ms_r;
    nb_nx_s    = nb_r;
    clr_s      = 1'b0;
    start_s    = 1'b0;
    if (stop) begin
      state_nx_s = IDLE;
      ch_nx_s    = CH_NONE;
      pend_nx_s  = 3'b000;
      ms_nx_s    = 16'd0;
      nb_nx_s    = 8'd0;
    end else if (state_r == IDLE) begin
      ms_nx_s = 16'd0;
      start_s = (sel_s != CH_NONE);
    end else if ((sel_s != CH_NONE) && (sel_s > ch_r)) begin
      start_s = 1'b1;
    end else if (done_s) begin
      case (state_r)
        ON: begin
          if (last_on_s) begin
            if (sel_s != CH_NONE) begin
              start_s = 1'b1;
            end else begin
              state_nx_s = IDLE;
              ch_nx_s    = CH_NONE;
              ms_nx_s    = 16'd0;
              nb_nx_s    = 8'd0;
            end
          end else begin
            state_nx_s = OFF;
            nb_nx_s    = nb_r + 8'd1;
            ms_nx_s    = 16'd0;
            clr_s      = 1'b1;
          end
        end
        OFF: begin
          state_nx_s = ON;
          ms_nx_s    = 16'd0;
          clr_s      = 1'b1;
        end
        default: begin
          state_nx_s = IDLE;
          ch_nx_s    = CH_NONE;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end

    if (start_s) begin
      state_nx_s = ON;
      ch_nx_s    = sel_s;
      pend_nx_s  = pend_v_s & ~ch_mask(sel_s);
      ms_nx_s    = 16'd0;
      nb_nx_s    = 8'd0;
      clr_s      = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  // Scheduler FSM; outputs are registered copies of the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ch_r        <= CH_NONE;
      pend_r      <= 3'b000;
      ms_r        <= 16'd0;
      nb_r        <= 8'd0;
      en_buz_r    <= 1'b0;
      busy_r      <= 1'b0;
      active_ch_r <= CH_NONE;
    end else begin
      state_r     <= state_nx_s;
      ch_r        <= ch_nx_s;
      pend_r      <= pend_nx_s;
      ms_r        <= ms_nx_s;
      nb_r        <= nb_nx_s;
      en_buz_r    <= (state_r == ON);
      busy_r      <= (state_r != IDLE);
      active_ch_r <= ch_r;
    end
  end

  assign en_buz    = en_buz_r;
  assign busy      = busy_r;
  assign active_ch = active_ch_r;

endmodule

// File: tb/tb_buzz_sched.sv
// Randomised bench for buzz_sched against a pattern-timeline reference model.
module tb_buzz_sched;

  localparam int TD = 4, C_ON = 2, B_ON = 3, B_OFF = 2, B_CNT = 2, A_ON = 2, A_OFF = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic       stop;
  logic       en_buz, busy;
  logic [1:0] active_ch;

  int checks = 0;
  int errors = 0;

  int         m_cur;
  int         m_t;
  logic [2:0] m_pend;
  logic       exp_en, exp_busy;
  logic [1:0] exp_ch;

  always #5 clk = ~clk;

  buzz_sched #(
    .TICK_DIV(TD), .CLICK_ON(C_ON), .BEEP_ON(B_ON), .BEEP_OFF(B_OFF),
    .BEEP_CNT(B_CNT), .ALARM_ON(A_ON), .ALARM_OFF(A_OFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .stop(stop),
    .en_buz(en_buz), .busy(busy), .active_ch(active_ch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Total pattern length in cycles; alarm never ends on its own.
  function automatic int pat_len(input int ch);
    if (ch == 0) return C_ON * TD;
    if (ch == 1) return (B_CNT * B_ON + (B_CNT - 1) * B_OFF) * TD;
    return -1;
  endfunction

  function automatic bit pat_on(input int ch, input int t);
    if (ch == 0) return 1'b1;
    if (ch == 1) return (t % ((B_ON + B_OFF) * TD)) < (B_ON * TD);
    return (t % ((A_ON + A_OFF) * TD)) < (A_ON * TD);
  endfunction

  function automatic void model_reset();
    m_cur = -1; m_t = 0; m_pend = 3'b000;
    exp_en = 1'b0; exp_busy = 1'b0; exp_ch = 2'd3;
  endfunction

  function automatic void model_step(input logic [2:0] r, input logic s);
    logic [2:0] mask;
    if (s) begin
      m_cur = -1; m_t = 0; m_pend = 3'b000;
      return;
    end
    mask = 3'b000;
    if (m_cur >= 0) mask[m_cur] = 1'b1;
    m_pend = m_pend | (r & ~mask);
    if (m_cur >= 0) begin
      m_t++;
      if (pat_len(m_cur) > 0 && m_t == pat_len(m_cur)) m_cur = -1;
    end
    for (int c = 2; c >= 0; c--) begin
      if (m_pend[c]) begin
        if (c > m_cur) begin
          m_cur = c; m_t = 0; m_pend[c] = 1'b0;
        end
        break;
      end
    end
  endfunction

  task automatic check_outs();
    chk("en_buz", 32'(en_buz), 32'(exp_en));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("active_ch", 32'(active_ch), 32'(exp_ch));
  endtask

  // One clock: check outputs, drive inputs, then advance the model at the edge.
  task automatic step(input logic [2:0] r, input logic s);
    @(negedge clk);
    check_outs();
    req  = r;
    stop = s;
    @(posedge clk);
    exp_en   = (m_cur >= 0) && pat_on(m_cur, m_t);
    exp_busy = (m_cur >= 0);
    exp_ch   = (m_cur < 0) ? 2'd3 : 2'(m_cur);
    model_step(r, s);
  endtask

  task automatic idle(input int n);
    repeat (n) step(3'b000, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 3'b111;
    stop  = 1'b0;
    model_reset();
    #1 check_outs();
    repeat (n) begin
      @(negedge clk);
      check_outs();
    end
    @(negedge clk);
    req   = 3'b000;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 3'b111;
    stop  = 1'b0;
    model_reset();
    do_reset(4);

    step(3'b001, 1'b0); idle(14);
    step(3'b010, 1'b0); idle(40);
    step(3'b100, 1'b0); idle(29); step(3'b000, 1'b1); idle(5);
    step(3'b010, 1'b0); idle(4);  step(3'b100, 1'b0); idle(3);
    step(3'b001, 1'b0); idle(10); step(3'b000, 1'b1); idle(2);
    step(3'b001, 1'b0); idle(12);
    step(3'b010, 1'b0); idle(10); step(3'b001, 1'b0); idle(40);
    step(3'b100, 1'b0); step(3'b100, 1'b0); idle(20);
    step(3'b011, 1'b1); idle(10);

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] r;
      logic       s;
      r[0] = ($urandom_range(0, 29) == 0);
      r[1] = ($urandom_range(0, 59) == 0);
      r[2] = ($urandom_range(0, 149) == 0);
      s    = ($urandom_range(0, 199) == 0);
      if (i == 1500) do_reset(3);
      step(r, s);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
